decoder3_8_seq: RTL and testbench

- Sequential 3-to-8 line decoder; the decode side of the 8-to-3 priority encoder.
- Accepts 3-bit binary codes over a valid/ready handshake and buffers them in a small FIFO.
- Drives each decoded code as an active-high one-hot word on Y for a programmable number of cycles.
- Used to replay encoder output onto LED/indicator lines at a human- or bench-observable rate.

---
 rtl/decoder3_8_seq.sv | 134 +++++++++++++
 tb/tb_decoder3_8_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder3_8_seq.sv
// Sequential 3-to-8 decoder: buffers 3-bit codes in a small FIFO and replays
// each one as an active-high one-hot word on Y for HOLD cycles.
module decoder3_8_seq #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    A,
  input  logic          EN,
  output logic [7:0]    Y,
  output logic          busy,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = 3;
  localparam int unsigned YW = 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Handshake and occupancy flags, derived from registered state only
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

  // Hold sequencer: loads the FIFO head as a one-hot word and times its hold
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    y_d     = y_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        y_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          y_d     = YW'(1) << mem_q[rd_ptr_q];
          timer_d = TW'(HOLD - 1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (!empty) begin
          // Chain straight into the next code with no idle gap
          pop     = 1'b1;
          y_d     = YW'(1) << mem_q[rd_ptr_q];
          timer_d = TW'(HOLD - 1);
        end else begin
          y_d     = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        y_d     = '0;
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = A;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset that discards all pending codes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      y_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      y_q      <= y_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Output mask and status
  assign Y     = y_q & {YW{EN}};
  assign busy  = (state_q == ST_HOLD) || !empty;
  assign count = count_q;

endmodule

// File: tb/tb_decoder3_8_seq.sv
// Bench for decoder3_8_seq: two instances (HOLD=4 and HOLD=1) against a
// timeline model where each accepted code owns a display window.
module tb_decoder3_8_seq;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int H0    = 4;
  localparam int H1    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       EN  = 1'b1;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [2:0] A0 = '0, A1 = '0;
  logic       in_ready0, in_ready1;
  logic [7:0] Y0, Y1;
  logic       busy0, busy1;
  logic [CW-1:0] count0, count1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  decoder3_8_seq #(.HOLD(H0), .DEPTH(DEPTH), .CW(CW)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .A(A0), .EN(EN), .Y(Y0), .busy(busy0), .count(count0)
  );

  decoder3_8_seq #(.HOLD(H1), .DEPTH(DEPTH), .CW(CW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(A1), .EN(EN), .Y(Y1), .busy(busy1), .count(count1)
  );

  // Model: each accepted code is displayed during edges [start, start+hold)
  typedef struct {
    int     inst;
    int     code;
    longint start;
  } ent_t;

  ent_t   q[$];
  longint cyc = 0;
  longint prev_end[2] = '{0, 0};
  bit     model_live = 1'b0;
  bit     acc0 = 1'b0, acc1 = 1'b0;
  bit     rdy0_pre, rdy1_pre;

  function automatic int hold_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int m_count(input int i);
    int n = 0;
    foreach (q[k]) if (q[k].inst == i && q[k].start > cyc) n++;
    return n;
  endfunction

  function automatic logic [7:0] m_y(input int i);
    logic [7:0] one = 8'd1;
    foreach (q[k])
      if (q[k].inst == i && q[k].start <= cyc && cyc < q[k].start + hold_of(i))
        return one << q[k].code;
    return 8'd0;
  endfunction

  function automatic bit m_busy(input int i);
    foreach (q[k]) if (q[k].inst == i && q[k].start + hold_of(i) > cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_push(input int i, input int code);
    ent_t   e;
    longint s;
    s = (cyc + 1 > prev_end[i]) ? cyc + 1 : prev_end[i];
    e.inst  = i;
    e.code  = code;
    e.start = s;
    q.push_back(e);
    prev_end[i] = s + hold_of(i);
  endtask

  // Model update at every rising edge
  always @(posedge clk) begin
    rdy0_pre = !rst && (m_count(0) < DEPTH);
    rdy1_pre = !rst && (m_count(1) < DEPTH);
    cyc++;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      q.delete();
      prev_end   = '{0, 0};
      model_live = 1'b1;
    end else begin
      if (in_valid0 && rdy0_pre) begin m_push(0, int'(A0)); acc0 = 1'b1; end
      if (in_valid1 && rdy1_pre) begin m_push(1, int'(A1)); acc1 = 1'b1; end
    end
    for (int k = q.size() - 1; k >= 0; k--)
      if (q[k].start + hold_of(q[k].inst) <= cyc) q.delete(k);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle, both instances against the model
  always @(negedge clk) begin
    if (model_live) begin
      chk("y0",      Y0,        EN ? m_y(0) : 8'd0);
      chk("y1",      Y1,        EN ? m_y(1) : 8'd0);
      chk("count0",  count0,    m_count(0));
      chk("count1",  count1,    m_count(1));
      chk("busy0",   busy0,     m_busy(0));
      chk("busy1",   busy1,     m_busy(1));
      chk("ready0",  in_ready0, !rst && m_count(0) < DEPTH);
      chk("ready1",  in_ready1, !rst && m_count(1) < DEPTH);
      chk("onehot0", $countones(Y0) <= 1, 1);
      chk("onehot1", $countones(Y1) <= 1, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, guard, peak;
    logic [7:0] exp_y;

    // Reset
    repeat (3) tick();
    @(negedge clk);
    chk("rst_y0", Y0, 8'h00);
    chk("rst_ready0", in_ready0, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", in_ready0, 1);
    chk("post_rst_busy0", busy0, 0);

    // Single code A=5
    in_valid0 = 1'b1; A0 = 3'd5;
    tick();
    for (int e = 1; e <= 5; e++) begin
      if (e == 1) in_valid0 = 1'b0;
      tick();
      @(negedge clk);
      chk("single_y", Y0, (e <= 4) ? 8'h20 : 8'h00);
      if (e == 5) chk("single_busy", busy0, 0);
    end
    repeat (3) tick();

    // Back-to-back 7,0,3 with no gap between codes
    in_valid0 = 1'b1; A0 = 3'd7;
    tick();
    for (int e = 1; e <= 13; e++) begin
      if (e == 1) A0 = 3'd0;
      if (e == 2) A0 = 3'd3;
      if (e == 3) in_valid0 = 1'b0;
      tick();
      @(negedge clk);
      exp_y = (e <= 4) ? 8'h80 : (e <= 8) ? 8'h01 : (e <= 12) ? 8'h08 : 8'h00;
      chk("b2b_y", Y0, exp_y);
    end
    repeat (3) tick();

    // Continuous valid with codes 0..7: fill, stall while full, wrap pointers
    idx = 0; guard = 0; peak = 0;
    in_valid0 = 1'b1; A0 = 3'd0;
    while (idx < 8 && guard < 200) begin
      tick();
      guard++;
      if (acc0) idx++;
      if (idx < 8) A0 = 3'(idx);
      else in_valid0 = 1'b0;
      @(negedge clk);
      if (int'(count0) > peak) peak = int'(count0);
    end
    chk("fill_in_time", guard < 200, 1);
    chk("fill_accepted", idx, 8);
    chk("peak_count", peak, DEPTH);
    repeat (40) tick();

    // EN low in the second cycle of an A=2 hold
    in_valid0 = 1'b1; A0 = 3'd2;
    tick();
    for (int e = 1; e <= 5; e++) begin
      if (e == 1) in_valid0 = 1'b0;
      tick();
      if (e == 2) EN = 1'b0;
      if (e == 3) EN = 1'b1;
      @(negedge clk);
      chk("en_y", Y0, (e <= 4 && e != 2) ? 8'h04 : 8'h00);
      if (e == 5) chk("en_busy_done", busy0, 0);
    end
    repeat (3) tick();

    // Reset mid-hold with two codes queued
    in_valid0 = 1'b1; A0 = 3'd1;
    tick();
    A0 = 3'd2;
    tick();
    A0 = 3'd3;
    tick();
    in_valid0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_count", count0, 2);
    chk("pre_rst_y", Y0, 8'h02);
    tick();
    @(negedge clk);
    chk("mid_rst_y", Y0, 8'h00);
    chk("mid_rst_count", count0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_ready", in_ready0, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", in_ready0, 1);
    repeat (10) tick();

    // HOLD=1 instance: A=1,6 back-to-back
    in_valid1 = 1'b1; A1 = 3'd1;
    tick();
    for (int e = 1; e <= 3; e++) begin
      if (e == 1) A1 = 3'd6;
      if (e == 2) in_valid1 = 1'b0;
      tick();
      @(negedge clk);
      chk("h1_y", Y1, (e == 1) ? 8'h02 : (e == 2) ? 8'h40 : 8'h00);
    end
    repeat (3) tick();

    // Randomized traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      tick();
      in_valid0 = 1'($urandom_range(0, 1));
      in_valid1 = 1'($urandom_range(0, 1));
      A0  = 3'($urandom_range(0, 7));
      A1  = 3'($urandom_range(0, 7));
      EN  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    tick();
    rst = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; EN = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    chk("drain_busy0", busy0, 0);
    chk("drain_busy1", busy1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
